board_io: RTL

Parametrised board I/O front-end between the SoC core and the FPGA board pins, replacing a bare pin-to-SoC wrapper. It generates a stretched power-on reset for the SoC. It synchronises and debounces raw push-buttons into stable levels plus one-cycle press events. It drives the LEDs through per-LED PWM brightness control.

---
 rtl/board_io.sv | 96 +++++++++
 1 files changed

// File: rtl/board_io.sv
// board_io: power-on reset stretcher, button debouncer and per-LED PWM driver between the SoC and board pins
module board_io #(
    parameter int NUM_LEDS        = 8,
    parameter int PWM_BITS        = 4,
    parameter int NUM_BTNS        = 6,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int POR_CYCLES      = 1024
) (
    input  logic                         bio_clk_i,
    input  logic                         bio_rst_ni,
    output logic                         bio_soc_rst_o,
    input  logic [NUM_LEDS*PWM_BITS-1:0] bio_led_level_i,
    output logic [NUM_LEDS-1:0]          bio_leds_o,
    input  logic [NUM_BTNS-1:0]          bio_btn_ni,
    output logic [NUM_BTNS-1:0]          bio_btn_o,
    output logic [NUM_BTNS-1:0]          bio_btn_press_o
);
    localparam int PW = $clog2(POR_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0]       POR_MAX = PW'(POR_CYCLES);
    localparam logic [DW-1:0]       DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [PW-1:0]                        por_cnt;
    logic [NUM_BTNS-1:0]                  sync1, sync2, btn_sync, btn_d;
    logic [NUM_BTNS-1:0][DW-1:0]          deb_cnt;
    logic [PWM_BITS-1:0]                  pwm_cnt;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]    shadow, eff;
    logic [NUM_LEDS-1:0]                  led_next;

    // POR stretch: count up from release and saturate; SoC held in reset until saturation
    always_ff @(posedge bio_clk_i or negedge bio_rst_ni)
        if (!bio_rst_ni) por_cnt <= '0;
        else if (por_cnt != POR_MAX) por_cnt <= por_cnt + 1'b1;

    assign bio_soc_rst_o = por_cnt != POR_MAX;

    // Two-flop synchroniser on the raw active-low pins; idles at the released level
    always_ff @(posedge bio_clk_i or negedge bio_rst_ni)
        if (!bio_rst_ni) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bio_btn_ni;
            sync2 <= sync1;
        end

    assign btn_sync = ~sync2;

    // Debounce: accept a new level only after it has held long enough; any bounce restarts the count
    always_ff @(posedge bio_clk_i or negedge bio_rst_ni)
        if (!bio_rst_ni) begin
            deb_cnt   <= '0;
            bio_btn_o <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (btn_sync[i] == bio_btn_o[i]) deb_cnt[i] <= '0;
                else if (deb_cnt[i] == DEB_MAX) begin
                    bio_btn_o[i] <= btn_sync[i];
                    deb_cnt[i]   <= '0;
                end else deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end

    // Press pulse one cycle after the debounced level rises
    always_ff @(posedge bio_clk_i or negedge bio_rst_ni)
        if (!bio_rst_ni) begin
            btn_d           <= '0;
            bio_btn_press_o <= '0;
        end else begin
            btn_d           <= bio_btn_o;
            bio_btn_press_o <= bio_btn_o & ~btn_d;
        end

    // At period start the live level is used directly so the first compare already sees the new value
    always_comb begin
        eff      = shadow;
        led_next = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            eff[k]      = (pwm_cnt == '0) ? bio_led_level_i[k*PWM_BITS +: PWM_BITS] : shadow[k];
            led_next[k] = (pwm_cnt < eff[k]) && !bio_soc_rst_o;
        end
    end

    // Shared period counter, per-LED shadow latch and registered LED pins
    always_ff @(posedge bio_clk_i or negedge bio_rst_ni)
        if (!bio_rst_ni) begin
            pwm_cnt    <= '0;
            shadow     <= '0;
            bio_leds_o <= '0;
        end else begin
            pwm_cnt    <= (pwm_cnt == PWM_MAX) ? '0 : pwm_cnt + 1'b1;
            shadow     <= eff;
            bio_leds_o <= led_next;
        end
endmodule
